// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-register fields in, stall/flush/forward controls
// and performance counters out. The pipeline drives master; the controller is slave.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1, id_rs2;
  logic              id_use_rs1, id_use_rs2;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic              ex_memread, ex_regwrite;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;
  logic              branch_taken, mem_req, mem_ready;
  logic [1:0]        forward_a, forward_b;
  logic              pc_write, ifid_write, idex_write, exmem_write;
  logic              ifid_flush, idex_bubble, exmem_flush, memwb_bubble;
  logic              mem_error;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt, memwait_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_memread, ex_regwrite, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
           branch_taken, mem_req, mem_ready,
    input  forward_a, forward_b, pc_write, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_bubble, exmem_flush, memwb_bubble, mem_error,
           stall_cnt, flush_cnt, memwait_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_memread, ex_regwrite, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
           branch_taken, mem_req, mem_ready,
    output forward_a, forward_b, pc_write, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_bubble, exmem_flush, memwb_bubble, mem_error,
           stall_cnt, flush_cnt, memwait_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for a 5-stage RISC-V pipeline: EX forwarding selects,
// load-use/RAW stalls, taken-branch flushes, memory-wait freeze FSM and counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int FWD_ENABLE  = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;

  state_t             state_reg;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic               mem_error_reg;
  logic [CNT_W-1:0]   stall_cnt_reg, flush_cnt_reg, memwait_cnt_reg;

  logic [1:0][REG_AW-1:0] ex_rs, id_rs;
  logic [1:0]             id_use;
  logic [1:0][1:0]        fwd_sel;
  logic [1:0]             ex_hit, mem_hit, wb_hit;
  logic                   hz_match, frz, br, hz_stall;
  logic [WAIT_W-1:0]      wait_inc;

  assign ex_rs  = {hz.ex_rs2, hz.ex_rs1};
  assign id_rs  = {hz.id_rs2, hz.id_rs1};
  assign id_use = {hz.id_use_rs2, hz.id_use_rs1};

  // Operand 0 is rs1 / forward_a, operand 1 is rs2 / forward_b.
  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    assign fwd_sel[gi] =
        (FWD_ENABLE == 0) ? 2'b00 :
        (hz.mem_regwrite && hz.mem_rd != '0 && hz.mem_rd == ex_rs[gi]) ? 2'b10 :
        (hz.wb_regwrite  && hz.wb_rd  != '0 && hz.wb_rd  == ex_rs[gi]) ? 2'b01 : 2'b00;

    assign ex_hit[gi]  = id_use[gi] && hz.ex_regwrite  && hz.ex_rd  != '0 && hz.ex_rd  == id_rs[gi];
    assign mem_hit[gi] = id_use[gi] && hz.mem_regwrite && hz.mem_rd != '0 && hz.mem_rd == id_rs[gi];
    assign wb_hit[gi]  = id_use[gi] && hz.wb_regwrite  && hz.wb_rd  != '0 && hz.wb_rd  == id_rs[gi];
  end

  // With forwarding only a load in EX cannot be bypassed in time; without it every
  // in-flight producer of an ID source must drain first.
  assign hz_match = (FWD_ENABLE != 0) ? (hz.ex_memread && |ex_hit)
                                      : |(ex_hit | mem_hit | wb_hit);

  assign frz = (state_reg == RUN && hz.mem_req && !hz.mem_ready && !hz.branch_taken) ||
               (state_reg == MEM_WAIT && !hz.mem_ready) ||
               (state_reg == MEM_ERR);
  assign br       = hz.branch_taken && !frz;
  assign hz_stall = hz_match && !br && !frz;
  assign wait_inc = wait_cnt_reg + WAIT_W'(1);

  always_comb begin
    hz.forward_a    = fwd_sel[0];
    hz.forward_b    = fwd_sel[1];
    hz.pc_write     = 1'b1;
    hz.ifid_write   = 1'b1;
    hz.idex_write   = 1'b1;
    hz.exmem_write  = 1'b1;
    hz.ifid_flush   = 1'b0;
    hz.idex_bubble  = 1'b0;
    hz.exmem_flush  = 1'b0;
    hz.memwb_bubble = 1'b0;
    if (reset) begin
      hz.forward_a = 2'b00;
      hz.forward_b = 2'b00;
    end else if (frz) begin
      hz.pc_write     = 1'b0;
      hz.ifid_write   = 1'b0;
      hz.idex_write   = 1'b0;
      hz.exmem_write  = 1'b0;
      hz.memwb_bubble = 1'b1;
    end else if (br) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
      hz.exmem_flush = 1'b1;
    end else if (hz_stall) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= '0;
      mem_error_reg   <= 1'b0;
      stall_cnt_reg   <= '0;
      flush_cnt_reg   <= '0;
      memwait_cnt_reg <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          // The first frozen cycle already counts as wait cycle 1.
          if (hz.mem_req && !hz.mem_ready && !hz.branch_taken) begin
            wait_cnt_reg <= WAIT_W'(1);
            if (MEM_TIMEOUT <= 1) begin
              state_reg     <= MEM_ERR;
              mem_error_reg <= 1'b1;
            end else begin
              state_reg <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (hz.mem_ready) begin
            state_reg <= RUN;
          end else begin
            wait_cnt_reg <= wait_inc;
            if (int'(wait_inc) >= MEM_TIMEOUT) begin
              state_reg     <= MEM_ERR;
              mem_error_reg <= 1'b1;
            end
          end
        end
        MEM_ERR: state_reg <= MEM_ERR;
        default: state_reg <= RUN;
      endcase

      if (hz_stall && stall_cnt_reg != '1)   stall_cnt_reg   <= stall_cnt_reg + CNT_W'(1);
      if (br && flush_cnt_reg != '1)         flush_cnt_reg   <= flush_cnt_reg + CNT_W'(1);
      if (frz && memwait_cnt_reg != '1)      memwait_cnt_reg <= memwait_cnt_reg + CNT_W'(1);
    end
  end

  assign hz.mem_error   = mem_error_reg;
  assign hz.stall_cnt   = stall_cnt_reg;
  assign hz.flush_cnt   = flush_cnt_reg;
  assign hz.memwait_cnt = memwait_cnt_reg;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: instance A forwards (timeout 16, 32-bit counters),
// instance B stalls on every RAW (timeout 4, 4-bit counters to reach saturation).
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) if_a ();
  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  if_b ();

  pipeline_hazard_ctrl #(.REG_AW(5), .FWD_ENABLE(1), .MEM_TIMEOUT(16), .CNT_W(32))
    dut_a (.clk(clk), .reset(rst_a), .hz(if_a));
  pipeline_hazard_ctrl #(.REG_AW(5), .FWD_ENABLE(0), .MEM_TIMEOUT(4), .CNT_W(4))
    dut_b (.clk(clk), .reset(rst_b), .hz(if_b));

  // Control word: {fwd_a, fwd_b, pc, ifid, idex, exmem, ifid_flush, idex_bubble, exmem_flush, memwb_bubble}
  wire [11:0] ctrl_a = {if_a.forward_a, if_a.forward_b, if_a.pc_write, if_a.ifid_write,
                        if_a.idex_write, if_a.exmem_write, if_a.ifid_flush, if_a.idex_bubble,
                        if_a.exmem_flush, if_a.memwb_bubble};
  wire [11:0] ctrl_b = {if_b.forward_a, if_b.forward_b, if_b.pc_write, if_b.ifid_write,
                        if_b.idex_write, if_b.exmem_write, if_b.ifid_flush, if_b.idex_bubble,
                        if_b.exmem_flush, if_b.memwb_bubble};

  typedef struct {
    string       tag;
    int          probe;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  step_no = 0;

  function automatic logic [11:0] c_norm(logic [1:0] fa, logic [1:0] fb);
    return {fa, fb, 4'b1111, 4'b0000};
  endfunction
  function automatic logic [11:0] c_hz();
    return {4'b0000, 4'b0011, 4'b0100};
  endfunction
  function automatic logic [11:0] c_br();
    return {4'b0000, 4'b1111, 4'b1110};
  endfunction
  function automatic logic [11:0] c_frz();
    return {4'b0000, 4'b0000, 4'b0001};
  endfunction

  function automatic logic [31:0] probe(int id);
    case (id)
      0: return {20'd0, ctrl_a};
      1: return if_a.stall_cnt;
      2: return if_a.flush_cnt;
      3: return if_a.memwait_cnt;
      4: return {31'd0, if_a.mem_error};
      5: return {20'd0, ctrl_b};
      6: return {28'd0, if_b.stall_cnt};
      7: return {28'd0, if_b.flush_cnt};
      8: return {28'd0, if_b.memwait_cnt};
      default: return {31'd0, if_b.mem_error};
    endcase
  endfunction

  task automatic push(input string tag, input int pr, input logic [31:0] v);
    sb_t e;
    e.tag = tag; e.probe = pr; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic exp_cnt_a(input string tag, input int st, input int fl, input int mw, input int er);
    push({tag, "_stall_a"}, 1, st); push({tag, "_flush_a"}, 2, fl);
    push({tag, "_mwait_a"}, 3, mw); push({tag, "_err_a"}, 4, er);
  endtask
  task automatic exp_cnt_b(input string tag, input int st, input int fl, input int mw, input int er);
    push({tag, "_stall_b"}, 6, st); push({tag, "_flush_b"}, 7, fl);
    push({tag, "_mwait_b"}, 8, mw); push({tag, "_err_b"}, 9, er);
  endtask

  // Compare every queued expectation against the settled outputs, then advance one clock.
  task automatic cyc();
    sb_t e;
    logic [31:0] obs;
    int n;
    n = 0;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      obs = probe(e.probe);
      n_vec++; n++;
      assert (obs === e.exp)
        else begin
          n_err++;
          $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
        end
    end
    $display("step %0d: %0d checks", step_no, n);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    if_a.id_rs1 = '0; if_a.id_rs2 = '0; if_a.id_use_rs1 = 0; if_a.id_use_rs2 = 0;
    if_a.ex_rs1 = '0; if_a.ex_rs2 = '0; if_a.ex_rd = '0; if_a.ex_memread = 0; if_a.ex_regwrite = 0;
    if_a.mem_rd = '0; if_a.mem_regwrite = 0; if_a.wb_rd = '0; if_a.wb_regwrite = 0;
    if_a.branch_taken = 0; if_a.mem_req = 0; if_a.mem_ready = 0;
  endtask
  task automatic idle_b();
    if_b.id_rs1 = '0; if_b.id_rs2 = '0; if_b.id_use_rs1 = 0; if_b.id_use_rs2 = 0;
    if_b.ex_rs1 = '0; if_b.ex_rs2 = '0; if_b.ex_rd = '0; if_b.ex_memread = 0; if_b.ex_regwrite = 0;
    if_b.mem_rd = '0; if_b.mem_regwrite = 0; if_b.wb_rd = '0; if_b.wb_regwrite = 0;
    if_b.branch_taken = 0; if_b.mem_req = 0; if_b.mem_ready = 0;
  endtask
  task automatic load_use_a(input logic [4:0] r);
    if_a.ex_rd = r; if_a.ex_memread = 1; if_a.ex_regwrite = 1;
    if_a.id_rs1 = r; if_a.id_use_rs1 = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_a(); idle_b();
    // Reset overrides every hazard input
    rst_a = 1; rst_b = 1;
    load_use_a(5); if_a.mem_req = 1; if_a.branch_taken = 1;
    if_a.mem_rd = 3; if_a.mem_regwrite = 1; if_a.ex_rs1 = 3;
    if_b.ex_rd = 7; if_b.ex_regwrite = 1; if_b.id_rs1 = 7; if_b.id_use_rs1 = 1; if_b.mem_req = 1;
    push("rst_ctrl_a", 0, c_norm(0, 0)); push("rst_ctrl_b", 5, c_norm(0, 0));
    cyc();
    rst_a = 0; rst_b = 0; idle_a(); idle_b();
    push("idle_a", 0, c_norm(0, 0)); push("idle_b", 5, c_norm(0, 0));
    exp_cnt_a("rst", 0, 0, 0, 0); exp_cnt_b("rst", 0, 0, 0, 0);
    cyc();

    // Load-use on x5: one stall, then bypass from MEM/WB
    load_use_a(5);
    push("lu_stall", 0, c_hz()); cyc();
    idle_a(); if_a.mem_rd = 5; if_a.mem_regwrite = 1; if_a.id_rs1 = 5; if_a.id_use_rs1 = 1;
    push("lu_release", 0, c_norm(0, 0)); push("lu_cnt", 1, 1); cyc();
    idle_a(); if_a.ex_rs1 = 5; if_a.wb_rd = 5; if_a.wb_regwrite = 1;
    push("lu_fwd", 0, c_norm(2'b01, 0)); push("lu_cnt2", 1, 1); cyc();

    // Forwarding priority and x0
    idle_a(); if_a.mem_rd = 3; if_a.mem_regwrite = 1; if_a.wb_rd = 3; if_a.wb_regwrite = 1;
    if_a.ex_rs1 = 3; if_a.ex_rs2 = 3;
    push("fwd_prio", 0, c_norm(2'b10, 2'b10)); cyc();
    if_a.wb_rd = 4; if_a.ex_rs1 = 4; if_a.ex_rs2 = 3;
    push("fwd_mix", 0, c_norm(2'b01, 2'b10)); cyc();
    if_a.mem_rd = 0; if_a.wb_rd = 0; if_a.ex_rs1 = 0; if_a.ex_rs2 = 0;
    push("fwd_x0", 0, c_norm(0, 0)); cyc();
    if_a.mem_rd = 3; if_a.mem_regwrite = 0; if_a.wb_rd = 3; if_a.ex_rs1 = 3;
    push("fwd_norw", 0, c_norm(2'b01, 0)); cyc();

    // rs2 load-use gated by id_use_rs2; x0 load and non-load never stall
    idle_a(); if_a.ex_rd = 6; if_a.ex_memread = 1; if_a.ex_regwrite = 1; if_a.id_rs2 = 6;
    push("lu_nouse", 0, c_norm(0, 0)); cyc();
    if_a.id_use_rs2 = 1;
    push("lu_rs2", 0, c_hz()); cyc();
    idle_a(); load_use_a(0);
    push("lu_x0", 0, c_norm(0, 0)); push("lu_rs2_cnt", 1, 2); cyc();
    idle_a(); load_use_a(5); if_a.ex_memread = 0;
    push("alu_nostall", 0, c_norm(0, 0)); cyc();

    // Taken branch during a load-use match
    idle_a(); load_use_a(5); if_a.branch_taken = 1;
    push("br_over_hz", 0, c_br()); cyc();
    idle_a();
    push("br_after", 0, c_norm(0, 0)); exp_cnt_a("br", 2, 1, 0, 0); cyc();

    // Memory wait of 3 cycles; a concurrent load-use is masked by the freeze
    idle_a(); if_a.mem_req = 1;
    push("frz0", 0, c_frz()); cyc();
    load_use_a(5);
    push("frz1", 0, c_frz()); cyc();
    idle_a(); if_a.mem_req = 1;
    push("frz2", 0, c_frz()); cyc();
    if_a.mem_ready = 1;
    push("frz_release", 0, c_norm(0, 0)); cyc();
    idle_a();
    push("frz_after", 0, c_norm(0, 0)); exp_cnt_a("mw", 2, 1, 3, 0); cyc();
    if_a.mem_req = 1; if_a.mem_ready = 1;
    push("zero_wait", 0, c_norm(0, 0)); cyc();
    if_a.mem_ready = 0; if_a.branch_taken = 1;
    push("br_vs_req", 0, c_br()); cyc();
    idle_a();
    push("br_vs_req_after", 0, c_norm(0, 0)); exp_cnt_a("brreq", 2, 2, 3, 0); cyc();

    // Reset in the middle of a wait
    if_a.mem_req = 1;
    push("mid_frz0", 0, c_frz()); cyc();
    push("mid_frz1", 0, c_frz()); cyc();
    rst_a = 1;
    push("mid_rst", 0, c_norm(0, 0)); cyc();
    rst_a = 0; idle_a();
    push("mid_run", 0, c_norm(0, 0)); exp_cnt_a("mid", 0, 0, 0, 0); cyc();

    // No-forward instance: RAW on x7 stalls through EX, MEM and WB
    if_b.ex_rd = 7; if_b.ex_regwrite = 1; if_b.id_rs1 = 7; if_b.id_use_rs1 = 1;
    push("raw_ex", 5, c_hz()); cyc();
    idle_b(); if_b.mem_rd = 7; if_b.mem_regwrite = 1; if_b.id_rs1 = 7; if_b.id_use_rs1 = 1; if_b.ex_rs1 = 7;
    push("raw_mem", 5, c_hz()); cyc();
    idle_b(); if_b.wb_rd = 7; if_b.wb_regwrite = 1; if_b.id_rs1 = 7; if_b.id_use_rs1 = 1; if_b.ex_rs1 = 7;
    push("raw_wb", 5, c_hz()); cyc();
    idle_b(); if_b.ex_rs1 = 7; if_b.mem_rd = 7; if_b.mem_regwrite = 1;
    push("raw_done_nofwd", 5, c_norm(0, 0)); push("raw_cnt", 6, 3); cyc();

    // Saturation of the 4-bit stall counter (3 + 13 cycles > 15)
    idle_b(); if_b.wb_rd = 9; if_b.wb_regwrite = 1; if_b.id_rs2 = 9; if_b.id_use_rs2 = 1;
    for (int i = 0; i < 13; i++) begin
      push("sat_hz", 5, c_hz());
      if (i == 12) push("sat_pre", 6, 15);
      cyc();
    end
    idle_b();
    push("sat_after", 5, c_norm(0, 0)); push("sat_cnt", 6, 15); cyc();

    // Timeout: 4 wait cycles then sticky error, mem_ready ignored
    if_b.mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      push("to_frz", 5, c_frz()); push("to_err0", 9, 0); cyc();
    end
    if_b.mem_ready = 1;
    push("err_frz", 5, c_frz()); push("err_set", 9, 1); cyc();
    if_b.mem_req = 0;
    push("err_hold", 5, c_frz()); exp_cnt_b("err", 15, 0, 5, 1); cyc();
    rst_b = 1;
    push("err_rst", 5, c_norm(0, 0)); cyc();
    rst_b = 0; idle_b();
    push("err_cleared", 5, c_norm(0, 0)); exp_cnt_b("clr", 0, 0, 0, 0); cyc();
    if_b.mem_req = 1; if_b.mem_ready = 1;
    push("run_again", 5, c_norm(0, 0)); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
